// File: rtl/dqr_pipe.sv
// dqr_pipe: three-stage ReLU / requantise pipeline for the NPU datapath.
// Stage p0 applies ReLU and captures the per-beat configuration, stage p1
// forms the unsigned product with the requant multiplier, and stage p2
// rounds, saturates and drives the outputs. All stages share one enable,
// so a stalled output freezes the whole pipe and no beat is lost.
module dqr_pipe #(
   parameter int LANES  = 4,
   parameter int ACC_W  = 32,
   parameter int MULT_W = 16,
   parameter int OUT_W  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [LANES*ACC_W-1:0] i_data,
   input  logic                   i_last,
   input  logic                   i_output_layer,
   input  logic [MULT_W-1:0]      i_mult,
   input  logic [4:0]             i_shift,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [LANES*ACC_W-1:0] o_data,
   output logic                   o_last,
   output logic [LANES-1:0]       o_sat,
   input  logic                   i_sat_clr,
   output logic [CNT_W-1:0]       o_sat_count,
   output logic                   o_busy
);

   // Product width; one extra guard bit is added for the rounding sum.
   localparam int PW = ACC_W + MULT_W;

   // Negative accumulators clamp to zero; the result is non-negative.
   function automatic logic [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] x);
      return (x < 0) ? '0 : $unsigned(x);
   endfunction

   // Round-half-up right shift. The guard bit keeps p + 2^(s-1) exact.
   function automatic logic [PW:0] round_shift(input logic [PW-1:0] p,
                                               input logic [4:0]    s);
      logic [PW:0] bias;
      bias = '0;
      if (s != 5'd0) bias = {{PW{1'b0}}, 1'b1} << (s - 5'd1);
      return ({1'b0, p} + bias) >> s;
   endfunction

   // Clamp to OUT_W bits; the MSB of the result is the saturation flag.
   function automatic logic [OUT_W:0] saturate(input logic [PW:0] q);
      if (|q[PW:OUT_W]) return {1'b1, {OUT_W{1'b1}}};
      return {1'b0, q[OUT_W-1:0]};
   endfunction

   logic                   en;
   logic                   vld_p0, vld_p1, vld_p2;

   logic [ACC_W-1:0]       relu_d  [LANES];
   logic [ACC_W-1:0]       relu_p0 [LANES];
   logic                   mode_p0;
   logic [MULT_W-1:0]      mult_p0;
   logic [4:0]             shift_p0;
   logic                   last_p0;

   logic [PW-1:0]          prod_d  [LANES];
   logic [PW-1:0]          prod_p1 [LANES];
   logic [ACC_W-1:0]       relu_p1 [LANES];
   logic                   mode_p1;
   logic [4:0]             shift_p1;
   logic                   last_p1;

   logic [LANES*ACC_W-1:0] data_d;
   logic [LANES-1:0]       sat_d;

   // The pipe advances whenever the output register is empty or being drained.
   assign en      = !vld_p2 || i_ready;
   assign o_ready = en;
   assign o_valid = vld_p2;
   assign o_busy  = vld_p0 | vld_p1 | vld_p2;

   // ---- stage p0: ReLU on every incoming lane ----
   // Split the packed input into lanes and clamp negatives.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         relu_d[k] = relu($signed(i_data[k*ACC_W +: ACC_W]));
      end
   end

   // ---- stage p1: unsigned product with the beat's multiplier ----
   // ReLU output is non-negative, so a plain unsigned multiply is exact.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         prod_d[k] = {{MULT_W{1'b0}}, relu_p0[k]} * {{ACC_W{1'b0}}, mult_p0};
      end
   end

   // ---- stage p2: round, saturate or pass through ----
   // Select per lane between requantised and output-layer results.
   always_comb begin
      logic [OUT_W:0] qv;
      data_d = '0;
      sat_d  = '0;
      qv     = '0;
      for (int k = 0; k < LANES; k++) begin
         qv = saturate(round_shift(prod_p1[k], shift_p1));
         if (mode_p1) begin
            data_d[k*ACC_W +: ACC_W] = relu_p1[k];
         end else begin
            data_d[k*ACC_W +: ACC_W] = {{(ACC_W-OUT_W){1'b0}}, qv[OUT_W-1:0]};
            sat_d[k]                 = qv[OUT_W];
         end
      end
   end

   // Stage valids move together; reset flushes every in-flight beat.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else if (en) begin
         vld_p0 <= i_valid;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

   // Stage p0/p1 datapath registers; meaningless while their valid is low.
   always_ff @(posedge i_clk) begin
      if (en) begin
         for (int k = 0; k < LANES; k++) begin
            relu_p0[k] <= relu_d[k];
            relu_p1[k] <= relu_p0[k];
            prod_p1[k] <= prod_d[k];
         end
         mode_p0  <= i_output_layer;
         mult_p0  <= i_mult;
         shift_p0 <= i_shift;
         last_p0  <= i_last;
         mode_p1  <= mode_p0;
         shift_p1 <= shift_p0;
         last_p1  <= last_p0;
      end
   end

   // Output register; cleared on reset so the outputs read as zero.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_data <= '0;
         o_sat  <= '0;
         o_last <= 1'b0;
      end else if (en) begin
         o_data <= data_d;
         o_sat  <= sat_d;
         o_last <= last_p1;
      end
   end

   // Count delivered beats with any saturated lane; clear wins, no wrap.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_sat_count <= '0;
      end else if (i_sat_clr) begin
         o_sat_count <= '0;
      end else if (vld_p2 && i_ready && (|o_sat) && !(&o_sat_count)) begin
         o_sat_count <= o_sat_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_dqr_pipe.sv
// Testbench for dqr_pipe: directed scenarios plus randomized traffic,
// scored against a lane-arithmetic reference model and a beat queue.
module tb_dqr_pipe;
   localparam int LANES  = 4;
   localparam int ACC_W  = 32;
   localparam int MULT_W = 16;
   localparam int OUT_W  = 8;
   localparam int CNT_W  = 4;
   localparam int DW     = LANES * ACC_W;

   logic              clk = 1'b0;
   logic              i_reset, i_valid, o_ready, i_last, i_output_layer;
   logic [DW-1:0]     i_data, o_data;
   logic [MULT_W-1:0] i_mult;
   logic [4:0]        i_shift;
   logic              o_valid, i_ready, o_last, i_sat_clr, o_busy;
   logic [LANES-1:0]  o_sat;
   logic [CNT_W-1:0]  o_sat_count;

   dqr_pipe #(.LANES(LANES), .ACC_W(ACC_W), .MULT_W(MULT_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_data(i_data), .i_last(i_last), .i_output_layer(i_output_layer),
      .i_mult(i_mult), .i_shift(i_shift), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_last(o_last), .o_sat(o_sat), .i_sat_clr(i_sat_clr),
      .o_sat_count(o_sat_count), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0]    data;
      logic [LANES-1:0] sat;
      logic             last;
      int               acc_cyc;
   } beat_t;

   beat_t            exp_q[$];
   int               n_vec = 0;
   int               n_err = 0;
   int               cyc = 0;
   int               last_low_cyc = -1;
   int unsigned      mcnt = 0;
   int               ready_mode = 0;
   bit               stall_prev = 1'b0;
   logic [DW-1:0]    prev_data;
   logic [LANES-1:0] prev_sat;
   logic             prev_last;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: ReLU, then either passthrough or multiply/round/clamp per lane.
   function automatic void model(input logic [DW-1:0] d, input logic mode,
                                 input logic [MULT_W-1:0] m, input logic [4:0] sh,
                                 output logic [DW-1:0] od, output logic [LANES-1:0] sat);
      od  = '0;
      sat = '0;
      for (int k = 0; k < LANES; k++) begin
         longint          x;
         longint unsigned r, p, q, maxv;
         maxv = (64'd1 << OUT_W) - 64'd1;
         x = longint'($signed(d[k*ACC_W +: ACC_W]));
         r = (x < 0) ? 64'd0 : 64'(x);
         if (mode) begin
            od[k*ACC_W +: ACC_W] = r[ACC_W-1:0];
         end else begin
            p = r * 64'(m);
            q = (sh == 5'd0) ? p : ((p + (64'd1 << (sh - 5'd1))) >> sh);
            if (q > maxv) begin
               od[k*ACC_W +: ACC_W] = maxv[ACC_W-1:0];
               sat[k] = 1'b1;
            end else begin
               od[k*ACC_W +: ACC_W] = q[ACC_W-1:0];
            end
         end
      end
   endfunction

   function automatic logic [DW-1:0] pack4(input int a, input int b, input int c, input int d);
      return {32'(d), 32'(c), 32'(b), 32'(a)};
   endfunction

   function automatic logic [ACC_W-1:0] rnd_lane();
      int v;
      case ($urandom_range(0, 3))
         0:       v = int'($urandom_range(0, 1000));
         1:       v = -int'($urandom_range(1, 100000));
         2:       v = int'($urandom_range(0, 300));
         default: v = int'($urandom);
      endcase
      return v;
   endfunction

   // Downstream ready generator, updated mid-cycle after the active edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ($urandom_range(0, 3) != 0);
            default: i_ready = 1'b0;
         endcase
      end
   end

   // Monitor / scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      beat_t e;
      bit    deliv;
      cyc++;
      deliv = 1'b0;
      e.sat = '0;
      if (i_reset) begin
         exp_q.delete();
         mcnt       = 0;
         stall_prev = 1'b0;
      end else begin
         chk("sat_count", o_sat_count, mcnt);
         chk("ready", o_ready, (!o_valid || i_ready));
         chk("busy", o_busy, (exp_q.size() != 0));
         if (stall_prev) begin
            chk("stall_valid", o_valid, 1);
            chk("stall_data", o_data, prev_data);
            chk("stall_sat", o_sat, prev_sat);
            chk("stall_last", o_last, prev_last);
         end
         if (o_valid && exp_q.size() == 0) begin
            chk("spurious_valid", o_valid, 0);
         end else if (o_valid && i_ready) begin
            e = exp_q.pop_front();
            deliv = 1'b1;
            chk("data", o_data, e.data);
            chk("sat", o_sat, e.sat);
            chk("last", o_last, e.last);
            if (last_low_cyc < e.acc_cyc) chk("latency", cyc - e.acc_cyc, 3);
         end
         if (i_sat_clr) mcnt = 0;
         else if (deliv && (|e.sat) && mcnt != (2**CNT_W - 1)) mcnt++;
         if (!i_ready) last_low_cyc = cyc;
         if (i_valid && o_ready) begin
            beat_t n;
            logic [DW-1:0]    od;
            logic [LANES-1:0] os;
            model(i_data, i_output_layer, i_mult, i_shift, od, os);
            n.data    = od;
            n.sat     = os;
            n.last    = i_last;
            n.acc_cyc = cyc;
            exp_q.push_back(n);
         end
         stall_prev = o_valid && !i_ready;
         prev_data  = o_data;
         prev_sat   = o_sat;
         prev_last  = o_last;
      end
   end

   task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic mode,
                            input logic [MULT_W-1:0] m, input logic [4:0] sh);
      int t;
      i_valid = 1'b1;
      i_data = d;
      i_last = last;
      i_output_layer = mode;
      i_mult = m;
      i_shift = sh;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!o_ready && t < 200);
      if (!o_ready) chk("accept_timeout", o_ready, 1);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      do begin
         @(posedge clk);
         t++;
      end while (exp_q.size() != 0 && t < 500);
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
      #1;
   endtask

   initial begin
      i_reset = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0;
      i_output_layer = 1'b0; i_mult = '0; i_shift = '0;
      i_ready = 1'b1; i_sat_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_ready", o_ready, 1);
      chk("rst_busy", o_busy, 0);
      chk("rst_count", o_sat_count, 0);
      chk("rst_data", o_data, 0);
      chk("rst_sat", o_sat, 0);
      chk("rst_last", o_last, 0);
      i_reset = 1'b0;

      // Requant basic
      send_beat(pack4(100, -5, 0, 1000), 1'b1, 1'b0, 16'd16384, 5'd16);
      drain();

      // Rounding, then a shift-0 beat with lane 2 saturating
      send_beat(pack4(6, 5, 1, 3), 1'b0, 1'b0, 16'd1, 5'd2);
      send_beat(pack4(7, 255, 256, 0), 1'b1, 1'b0, 16'd1, 5'd0);
      drain();
      chk("cnt_round", o_sat_count, 1);

      // Saturation count, then clear coinciding with a saturating delivery
      i_sat_clr = 1'b1;
      @(posedge clk); #1;
      i_sat_clr = 1'b0;
      for (int i = 0; i < 3; i++) send_beat(pack4(2000, 0, 0, 0), 1'b0, 1'b0, 16'd16384, 5'd16);
      drain();
      chk("cnt_three", o_sat_count, 3);
      send_beat(pack4(2000, 0, 0, 0), 1'b0, 1'b0, 16'd16384, 5'd16);
      @(posedge clk);
      @(posedge clk); #1;
      chk("sat4_valid", o_valid, 1);
      chk("sat4_flag", o_sat, 4'b0001);
      i_sat_clr = 1'b1;
      @(posedge clk); #1;
      i_sat_clr = 1'b0;
      chk("cnt_clr_wins", o_sat_count, 0);
      drain();

      // Output-layer beat followed immediately by a requant beat
      send_beat(pack4(-7, 123456, 0, 1), 1'b0, 1'b1, 16'd16384, 5'd16);
      send_beat(pack4(100, -5, 0, 1000), 1'b1, 1'b0, 16'd16384, 5'd16);
      drain();
      chk("cnt_outlayer", o_sat_count, 0);

      // Backpressure: 8 beats while i_ready is held low for four cycles
      fork
         begin
            for (int i = 1; i <= 8; i++) send_beat(pack4(i, 0, 0, 0), (i == 8), 1'b0, 16'd1, 5'd0);
         end
         begin
            repeat (3) @(posedge clk);
            ready_mode = 2;
            repeat (4) @(posedge clk);
            ready_mode = 0;
         end
      join
      drain();

      // Randomized traffic with random backpressure and counter clears
      ready_mode = 1;
      for (int i = 0; i < 300; i++) begin
         logic [DW-1:0] d;
         for (int k = 0; k < LANES; k++) d[k*ACC_W +: ACC_W] = rnd_lane();
         i_sat_clr = ($urandom_range(0, 19) == 0);
         send_beat(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   16'($urandom_range(0, 65535)), 5'($urandom_range(0, 31)));
         i_sat_clr = 1'b0;
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
         end
      end
      ready_mode = 0;
      drain();

      // Reset with three beats in flight
      send_beat(pack4(2000, 0, 0, 0), 1'b0, 1'b0, 16'd16384, 5'd16);
      drain();
      chk("cnt_nonzero", (o_sat_count != 0), 1);
      for (int i = 0; i < 3; i++) send_beat(pack4(2000, 9, 9, 9), 1'b0, 1'b0, 16'd16384, 5'd16);
      #1;
      i_reset = 1'b1;
      #1;
      chk("mid_rst_valid", o_valid, 0);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_count", o_sat_count, 0);
      chk("mid_rst_ready", o_ready, 1);
      @(posedge clk);
      @(posedge clk); #1;
      i_reset = 1'b0;
      send_beat(pack4(40, 50, -60, 70), 1'b1, 1'b0, 16'd3, 5'd1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dqr_pipe.md
Name: dqr_pipe

Overview:
- Parametrised, pipelined successor to the single-lane combinational ReLU/requantise stage of the NPU datapath.
- Accepts LANES signed accumulator words per beat and applies ReLU to each lane.
- Each lane is then either passed through (output layer) or requantised with a fixed-point multiplier, rounding shift and saturation to OUT_W bits.
- Uses valid/ready handshakes on both sides and keeps a saturation statistics counter. Sits between the PE-array accumulators and the activation write-back buffer.

Parameters:
- LANES, 4, number of parallel lanes per beat.
- ACC_W, 32, accumulator width per lane (signed input, output lane width).
- MULT_W, 16, unsigned requant multiplier width.
- OUT_W, 8, quantised output width (unsigned).
- CNT_W, 16, saturation counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept a beat.
- i_data  in  LANES*ACC_W  signed accumulators; lane k occupies bits [k*ACC_W +: ACC_W].
- i_last  in  1  end-of-tile marker, carried with the beat.
- i_output_layer  in  1  1 = ReLU passthrough, 0 = requantise; sampled per beat.
- i_mult  in  MULT_W  requant multiplier; sampled per beat.
- i_shift  in  5  right-shift amount 0..31; sampled per beat.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts.
- o_data  out  LANES*ACC_W  results, same lane packing as i_data.
- o_last  out  1  i_last of the output beat.
- o_sat  out  LANES  per-lane saturation flag of the output beat.
- i_sat_clr  in  1  synchronous clear of o_sat_count.
- o_sat_count  out  CNT_W  count of accepted output beats with any o_sat bit set.
- o_busy  out  1  any pipeline stage holds a valid beat.

Behaviour:
- Reset (async, immediate): all stage valids 0, o_valid 0, o_data 0, o_last 0, o_sat 0, o_sat_count 0, o_busy 0. o_ready is 1 while in reset.
- Pipeline: three register stages S1, S2, S3; S3 drives the outputs.
- Global enable en = !o_valid || i_ready; o_ready = en. All stages advance together when en = 1, and each stage's valid propagates.
- A beat is accepted when i_valid && o_ready. A beat is delivered when o_valid && i_ready.
- Latency is exactly 3 cycles when unstalled; throughput is 1 beat per cycle.
- Stall: while en = 0, every stage holds. Data, mode, mult, shift, last and o_sat are stable while o_valid && !i_ready. No beat is dropped or duplicated.
- Bubbles (invalid stages) still advance on en. o_busy = S1v | S2v | S3v.
- S1: r = (x < 0) ? 0 : x per lane. Latch mode, mult, shift and last with the beat, so configuration changes mid-stream apply per beat.
- S2: p = r * mult, unsigned, ACC_W+MULT_W bits; p is never negative.
- S3, requant mode, shift s:
  - s = 0: q = p.
  - s > 0: q = (p + 2^(s-1)) >> s, i.e. round half up, computed with one guard bit so the addition cannot overflow.
  - If q > 2^OUT_W-1: lane output = 2^OUT_W-1 and o_sat[k] = 1; else lane output = q, o_sat[k] = 0.
  - Lane output is zero-extended to ACC_W.
- S3, output-layer mode: lane output = r (full ACC_W); o_sat = 0.
- Counter:
  - On a delivered beat with |o_sat, o_sat_count increments and saturates at all-ones; it does not wrap.
  - i_sat_clr has priority over a simultaneous increment; the result is 0.
- Reset mid-operation flushes all in-flight beats; nothing is output for them.

Test Plan:
- Requant basic: lanes {100, -5, 0, 1000}, mult = 16384, shift = 16, i_ready = 1 -> after 3 cycles o_data lanes {25, 0, 0, 250}, o_sat = 0000, o_last follows i_last.
- Rounding: mult = 1, shift = 2, lanes {6, 5, 1, 3} -> {2, 1, 0, 1}. Next beat with shift = 0, lanes {7, 255, 256, 0} -> {7, 255, 255, 0}, o_sat = 0100 (lane 2 is bit 2 of o_sat), o_sat_count = 1.
- Saturation/count: 3 beats each with lane0 = 2000, mult = 16384, shift = 16 -> lane0 = 255, o_sat[0] = 1, o_sat_count = 3. Pulse i_sat_clr in the same cycle as a 4th saturating delivery -> o_sat_count = 0.
- Output layer and per-beat mode switch: beat A with output_layer = 1, lanes {-7, 123456, 0, 1} -> {0, 123456, 0, 1}, o_sat = 0. Beat B immediately after with output_layer = 0 -> beat B is requantised while A is still output-layer; the count is unchanged by A.
- Backpressure: stream 8 beats with values 1..8 on lane0 (mult = 1, shift = 0). Hold i_ready low for cycles 4-7 -> outputs 1..8 in order with no loss or duplication; o_ready is low whenever o_valid && !i_ready; o_data is stable during the stall.
- Reset mid-stream: assert i_reset with 3 beats in flight -> o_valid and o_busy go to 0 without a clock edge, o_sat_count = 0. After release, a new beat appears exactly 3 cycles after its acceptance.
